// File: rtl/instr_sequencer.sv
// ============================================================================
// Module   : instr_sequencer
// Brief    : Program-buffer sequencer issuing one instruction per cycle to the
//            RV32I core, honouring stall; optional watchdog under the macro
//            INSTR_SEQ_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer #(
  parameter int             XLEN       = 32,
  parameter int             DEPTH      = 16,
  parameter int             CYC_W      = 16,
  parameter logic [XLEN-1:0] NOP       = 32'h0000_0013,
  parameter int             WDOG_LIMIT = 64,
  localparam int            AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [AW-1:0]    load_addr,
  input  logic [XLEN-1:0]  load_data,
  input  logic             start,
  input  logic [AW:0]      prog_len,
  input  logic             stall,
  output logic [XLEN-1:0]  instruction,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      issue_count,
  output logic [CYC_W-1:0] cycle_count,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [AW-1:0]     ptr_q;
  logic [AW:0]       len_q;
  logic [AW:0]       issue_q;
  logic [CYC_W-1:0]  cyc_q;

  logic              run_w;
  logic              start_acc_w;
  logic              accept_w;
  logic              last_w;
  logic              wdog_hit_w;

  if ((WDOG_LIMIT < 1) || (DEPTH < 2)) begin : g_bad_param
    $error("instr_sequencer: WDOG_LIMIT must be >= 1 and DEPTH >= 2");
  end

  assign run_w       = (state_q == S_RUN);
  assign start_acc_w = (state_q == S_IDLE) && start;
  assign accept_w    = run_w && !stall;
  assign last_w      = accept_w && ((issue_q + (AW+1)'(1)) == len_q);

  // Buffer is deliberately left unreset; writes only land while idle.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && load_valid) begin
      mem_q[load_addr] <= load_data;
    end
  end

`ifdef INSTR_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] stall_cnt_q;
  logic            timeout_q;

  assign wdog_hit_w = run_w && stall && (stall_cnt_q == WD_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else if (start_acc_w) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else if (run_w) begin
      if (!stall) begin
        stall_cnt_q <= '0;
      end else if (wdog_hit_w) begin
        stall_cnt_q <= '0;
        timeout_q   <= 1'b1;
      end else begin
        stall_cnt_q <= stall_cnt_q + WD_W'(1);
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign wdog_hit_w = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (prog_len != '0) ? S_RUN : S_DONE;
      S_RUN:  if (last_w || wdog_hit_w) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      issue_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q   <= prog_len;
            ptr_q   <= '0;
            issue_q <= '0;
            cyc_q   <= '0;
          end
        end
        S_RUN: begin
          if (cyc_q != '1) cyc_q <= cyc_q + CYC_W'(1);
          // ptr may wrap after the final entry of a full buffer; it is unused then.
          if (accept_w) begin
            ptr_q   <= ptr_q + AW'(1);
            issue_q <= issue_q + (AW+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign en          = run_w;
  assign busy        = run_w;
  assign done        = (state_q == S_DONE);
  assign instruction = run_w ? mem_q[ptr_q] : NOP;
  assign issue_count = issue_q;
  assign cycle_count = cyc_q;

endmodule

`default_nettype wire
